// File: rtl/ac97_pkg.sv
// ---------------------------------------------------------------------------
// ac97_pkg
// Shared definitions for the AC'97 codec-side responder: the frame layout
// (slot start/end bit indices), input/output tag bit positions, the codec
// register indices with special behaviour, and the default register values.
// Optional build macro used by the responder: AC97_SYNC_CHECK_EN.
// ---------------------------------------------------------------------------
package ac97_pkg;

   // One AC'97 data slot (slots 1-12 are 20 bits wide).
   typedef logic [19:0] slot_t;

   // Bit position within a 256-bit frame.
   typedef logic [7:0] bit_idx_t;

   // Link tracking state: no frame seen yet, or a frame is being counted.
   typedef enum logic {
      LINK_IDLE,
      LINK_OPEN
   } link_state_t;

   // Frame layout, as bit indices counted from the SYNC rising edge.
   localparam bit_idx_t TAG_START   = 8'd0;
   localparam bit_idx_t TAG_END     = 8'd15;
   localparam bit_idx_t SLOT1_START = 8'd16;
   localparam bit_idx_t SLOT1_END   = 8'd35;
   localparam bit_idx_t SLOT2_START = 8'd36;
   localparam bit_idx_t SLOT2_END   = 8'd55;
   localparam bit_idx_t SLOT3_START = 8'd56;
   localparam bit_idx_t SLOT3_END   = 8'd75;
   localparam bit_idx_t SLOT4_START = 8'd76;
   localparam bit_idx_t SLOT4_END   = 8'd95;
   localparam bit_idx_t FRAME_LAST  = 8'd255;

   // Tag bit positions (same meaning in both directions).
   localparam int TAG_FRAME_VALID = 15;
   localparam int TAG_SLOT1_VALID = 14;
   localparam int TAG_SLOT2_VALID = 13;
   localparam int TAG_SLOT3_VALID = 12;
   localparam int TAG_SLOT4_VALID = 11;

   // Register indices are the 7-bit AC'97 address shifted right by one:
   // 0x00 reset/ID, 0x26 power status, 0x7C vendor ID.
   localparam logic [5:0] REG_RESET  = 6'h00;
   localparam logic [5:0] REG_POWER  = 6'h13;
   localparam logic [5:0] REG_VENDOR = 6'h3E;

   // Nominal SYNC high time in bit clocks.
   localparam int SYNC_HIGH_CYCLES = 16;

   // Power-on / soft-reset contents of a codec register.
   function automatic logic [15:0] reg_default(input logic [5:0]  idx,
                                               input logic [15:0] vendor_id,
                                               input logic [15:0] pwr_status);
      case (idx)
         REG_RESET, REG_VENDOR: return vendor_id;
         REG_POWER:             return pwr_status;
         default:               return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/ac97_codec_responder_if.sv
// ---------------------------------------------------------------------------
// ac97_codec_responder_if
// The three serial AC'97 link wires between controller and codec.
//   SYNC      : frame sync, driven by the controller
//   SDATA_OUT : controller -> codec serial data, MSB first
//   SDATA_IN  : codec -> controller serial data, MSB first
// Modports: master = controller side, slave = codec side.
// ---------------------------------------------------------------------------
interface ac97_codec_responder_if;
   logic SYNC;
   logic SDATA_OUT;
   logic SDATA_IN;

   modport master (
      output SYNC,
      output SDATA_OUT,
      input  SDATA_IN
   );

   modport slave (
      input  SYNC,
      input  SDATA_OUT,
      output SDATA_IN
   );
endinterface

// File: rtl/ac97_regfile.sv
// ---------------------------------------------------------------------------
// ac97_regfile
// 64 x 16 codec register file indexed by (AC'97 address >> 1).
//   clock, reset_n : bit clock, asynchronous active-low reset
//   wr_en          : commit wr_data to wr_idx this edge
//   wr_idx/wr_data : write port; index 0 restores every default,
//                    the power-status and vendor-ID registers are read-only
//   rd_idx/rd_data : combinational read port
// ---------------------------------------------------------------------------
module ac97_regfile
   import ac97_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID  = 16'h4E53,
   parameter logic [15:0] PWR_STATUS = 16'h000F
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [5:0]  wr_idx,
   input  logic [15:0] wr_data,
   input  logic [5:0]  rd_idx,
   output logic [15:0] rd_data
);

   logic [15:0] regs [64];

   // Storage: reset (hard or via a write to index 0) reloads the defaults;
   // the read-only registers simply never take a write so they keep theirs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) begin
            regs[i] <= reg_default(6'(i), VENDOR_ID, PWR_STATUS);
         end
      end else if (wr_en) begin
         if (wr_idx == REG_RESET) begin
            for (int i = 0; i < 64; i++) begin
               regs[i] <= reg_default(6'(i), VENDOR_ID, PWR_STATUS);
            end
         end else if (wr_idx != REG_POWER && wr_idx != REG_VENDOR) begin
            regs[wr_idx] <= wr_data;
         end
      end
   end

   assign rd_data = regs[rd_idx];

endmodule

// File: rtl/ac97_codec_responder.sv
// ---------------------------------------------------------------------------
// ac97_codec_responder
// Codec-side AC'97 responder standing in for an LM4550. Decodes the
// controller's frames, holds the codec register file, answers register
// reads one frame later and loops DAC samples back as ADC samples.
//   clock       : BIT_CLK, rising edge only
//   reset_n     : asynchronous active-low reset
//   link        : SYNC / SDATA_OUT in, SDATA_IN out (slave modport)
//   dac_left    : last slot-3 sample received
//   dac_right   : last slot-4 sample received
//   dac_valid   : one-cycle pulse when dac_left/right update
//   codec_ready : codec-ready tag bit, set after READY_FRAMES frames
//   sync_err    : sticky SYNC framing error
// Build macro: AC97_SYNC_CHECK_EN enables the SYNC framing checker; without
// it sync_err is tied low.
// ---------------------------------------------------------------------------
module ac97_codec_responder
   import ac97_pkg::*;
#(
   parameter int          READY_FRAMES = 4,
   parameter logic [15:0] VENDOR_ID    = 16'h4E53,
   parameter logic [15:0] PWR_STATUS   = 16'h000F
) (
   input  logic                    clock,
   input  logic                    reset_n,
   ac97_codec_responder_if.slave   link,
   output logic [19:0]             dac_left,
   output logic [19:0]             dac_right,
   output logic                    dac_valid,
   output logic                    codec_ready,
   output logic                    sync_err
);

   localparam int CNT_W = (READY_FRAMES < 1) ? 1 : $clog2(READY_FRAMES + 1);

   link_state_t  state, state_next;
   logic         sync_prev;
   logic         sync_rise;
   bit_idx_t     bit_idx;
   bit_idx_t     cur_idx;
   logic         frame_active;

   logic [18:0]  in_shift;
   slot_t        in_next;
   logic [15:11] in_tag;
   logic [7:0]   in_cmd;
   slot_t        in_slot3;

   logic         wr_fire;
   logic         rd_fire;
   logic         dac_fire;
   logic [15:0]  reg_rd_data;

   logic         rd_pending;
   logic [6:0]   rd_addr;
   logic [15:0]  rd_data_q;
   logic         lb_valid;

   logic [15:0]  out_tag;
   logic [95:0]  out_frame;
   logic [95:0]  out_shift;
   logic [CNT_W-1:0] frame_cnt;

   // Link state register: remembers the previous SYNC sample and the index
   // of the bit sampled on the last edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= LINK_IDLE;
         sync_prev <= 1'b0;
         bit_idx   <= '0;
      end else begin
         state     <= state_next;
         sync_prev <= link.SYNC;
         bit_idx   <= cur_idx;
      end
   end

   // Works out which frame bit is being sampled on this edge. A SYNC rising
   // edge always restarts at 0, which also discards any partial frame;
   // otherwise an open frame just counts on and wraps 255 -> 0 free-running.
   always_comb begin
      sync_rise    = link.SYNC & ~sync_prev;
      state_next   = state;
      cur_idx      = '0;
      frame_active = 1'b0;
      case (state)
         LINK_IDLE: begin
            if (sync_rise) begin
               state_next   = LINK_OPEN;
               frame_active = 1'b1;
            end
         end
         LINK_OPEN: begin
            frame_active = 1'b1;
            cur_idx      = sync_rise ? 8'd0 : bit_idx + 8'd1;
         end
         default: state_next = LINK_IDLE;
      endcase
   end

   // The incoming bit is appended to the last 19 bits so each slot can be
   // acted on in the very edge its final bit arrives.
   assign in_next = {in_shift, link.SDATA_OUT};

   // Command decode, all evaluated on the edge of the last bit of the slot
   // that completes the command.
   assign wr_fire  = frame_active && cur_idx == SLOT2_END
                     && in_tag[TAG_FRAME_VALID] && in_tag[TAG_SLOT1_VALID]
                     && in_tag[TAG_SLOT2_VALID] && !in_cmd[7];
   assign rd_fire  = frame_active && cur_idx == SLOT2_END
                     && in_tag[TAG_FRAME_VALID] && in_tag[TAG_SLOT1_VALID]
                     && in_cmd[7];
   assign dac_fire = frame_active && cur_idx == SLOT4_END
                     && in_tag[TAG_SLOT3_VALID] && in_tag[TAG_SLOT4_VALID];

   // Input capture: keep only the tag valid bits, the slot-1 R/W bit and
   // address, and slot 3 until slot 4 completes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_shift <= '0;
         in_tag   <= '0;
         in_cmd   <= '0;
         in_slot3 <= '0;
      end else begin
         in_shift <= in_next[18:0];
         if (frame_active && cur_idx == TAG_END) begin
            in_tag <= in_next[15:11];
         end
         if (frame_active && cur_idx == SLOT1_END) begin
            in_cmd <= in_next[19:12];
         end
         if (frame_active && cur_idx == SLOT3_END) begin
            in_slot3 <= in_next;
         end
      end
   end

   ac97_regfile #(
      .VENDOR_ID  (VENDOR_ID),
      .PWR_STATUS (PWR_STATUS)
   ) u_regfile (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (wr_fire),
      .wr_idx  (in_cmd[6:1]),
      .wr_data (in_next[19:4]),
      .rd_idx  (in_cmd[6:1]),
      .rd_data (reg_rd_data)
   );

   // Pending read response and loopback flag. Both are consumed when the
   // next output frame is assembled at index 0, so each goes out once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_pending <= 1'b0;
         rd_addr    <= '0;
         rd_data_q  <= '0;
         lb_valid   <= 1'b0;
      end else begin
         if (frame_active && cur_idx == TAG_START) begin
            rd_pending <= 1'b0;
            lb_valid   <= 1'b0;
         end
         if (rd_fire) begin
            rd_pending <= 1'b1;
            rd_addr    <= in_cmd[6:0];
            rd_data_q  <= reg_rd_data;
         end
         if (dac_fire) begin
            lb_valid <= 1'b1;
         end
      end
   end

   // DAC outputs double as the loopback buffer for the next frame's slots.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dac_left  <= '0;
         dac_right <= '0;
         dac_valid <= 1'b0;
      end else begin
         dac_valid <= dac_fire;
         if (dac_fire) begin
            dac_left  <= in_slot3;
            dac_right <= in_next;
         end
      end
   end

   // Output frame image (tag and slots 1-4); slots 5-12 are zero.
   always_comb begin
      out_tag                  = '0;
      out_tag[TAG_FRAME_VALID] = codec_ready;
      out_tag[TAG_SLOT1_VALID] = rd_pending;
      out_tag[TAG_SLOT2_VALID] = rd_pending;
      out_tag[TAG_SLOT3_VALID] = lb_valid;
      out_tag[TAG_SLOT4_VALID] = lb_valid;
      out_frame = {out_tag,
                   rd_pending ? {1'b0, rd_addr, 12'h000} : 20'h00000,
                   rd_pending ? {rd_data_q, 4'h0}        : 20'h00000,
                   lb_valid   ? dac_left                 : 20'h00000,
                   lb_valid   ? dac_right                : 20'h00000};
   end

   // Serialiser: at index 0 the frame image is loaded and its MSB goes out
   // immediately, giving a fixed one-bit lag behind the input stream.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         link.SDATA_IN <= 1'b0;
         out_shift     <= '0;
      end else if (frame_active && cur_idx == TAG_START) begin
         link.SDATA_IN <= out_frame[95];
         out_shift     <= {out_frame[94:0], 1'b0};
      end else if (frame_active) begin
         link.SDATA_IN <= out_shift[95];
         out_shift     <= {out_shift[94:0], 1'b0};
      end else begin
         link.SDATA_IN <= 1'b0;
      end
   end

   // Codec-ready: count frames reaching index 255 until enough have passed,
   // then hold ready until the next reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt   <= '0;
         codec_ready <= 1'b0;
      end else if (frame_active && cur_idx == FRAME_LAST && !codec_ready) begin
         frame_cnt <= frame_cnt + 1'b1;
         if (frame_cnt == CNT_W'(READY_FRAMES - 1)) begin
            codec_ready <= 1'b1;
         end
      end
   end

`ifdef AC97_SYNC_CHECK_EN
   logic [4:0] sync_high_cnt;

   // SYNC framing checker: flags a rising edge anywhere but the wrap to
   // index 0 of an open frame, and any high pulse not exactly 16 clocks.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_high_cnt <= '0;
         sync_err      <= 1'b0;
      end else begin
         if (sync_rise) begin
            sync_high_cnt <= 5'd1;
         end else if (link.SYNC && sync_high_cnt != 5'h1F) begin
            sync_high_cnt <= sync_high_cnt + 5'd1;
         end
         if (sync_rise && state == LINK_OPEN && bit_idx != FRAME_LAST) begin
            sync_err <= 1'b1;
         end
         if (!link.SYNC && sync_prev && sync_high_cnt != 5'(SYNC_HIGH_CYCLES)) begin
            sync_err <= 1'b1;
         end
      end
   end
`else
   assign sync_err = 1'b0;
`endif

endmodule

// File: doc/ac97_codec_responder.md
Name: ac97_codec_responder

Overview:
- Synthesizable AC'97 codec-side responder. It is the far end of the link driven by the LM4550 controller.
- Decodes SYNC/SDATA_OUT frames, keeps a 64x16 codec register file, and answers register reads and DAC samples on SDATA_IN.
- Used as an on-FPGA/bench stand-in for the LM4550, so the controller, ioports register access and psdi_dsp audio path can run with no external codec.
- Runs entirely in the BIT_CLK domain (12.288 MHz).

Parameters:
- READY_FRAMES, 4: complete frames after reset before tag bit 15 (codec ready) is asserted.
- VENDOR_ID, 16'h4E53: value read from register 0x7C. Also the reset value of register 0x00.
- PWR_STATUS, 16'h000F: reset and read value of register 0x26 (ADC/DAC/ANL/REF ready).

Ports:
- clock  in  1  bit clock, rising edge only.
- reset_n  in  1  asynchronous, active-low reset.
- SYNC  in  1  frame sync from controller.
- SDATA_OUT  in  1  serial stream from controller, MSB first.
- SDATA_IN  out  1  serial stream to controller, MSB first.
- dac_left  out  20  last slot-3 sample received.
- dac_right  out  20  last slot-4 sample received.
- dac_valid  out  1  one-cycle pulse when dac_left/right update.
- codec_ready  out  1  mirrors tag bit 15.
- sync_err  out  1  sticky frame-error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; bit counter idle (no frame open); register file at defaults; pending read and loopback buffers cleared.
- Frame start:
  - SYNC sampled 0 then 1 on consecutive rising edges marks the first sampled cycle as bit index 0.
  - The 8-bit index then increments each cycle and wraps 255 -> 0.
- Frame layout (bit indices):
  - slot0 tag 0-15.
  - slot1 16-35, slot2 36-55, slot3 56-75, slot4 76-95.
  - slots 5-12 are ignored on input and driven 0 on output.
- Input tag: bit15 = frame valid, bit14 = slot1 valid, bit13 = slot2 valid, bit12 = slot3 valid, bit11 = slot4 valid.
- Register write:
  - Condition: frame valid, slot1 and slot2 valid, slot1[19] = 0.
  - Slot fields: register index = slot1[18:13]; data = slot2[19:4].
  - The write commits in the cycle after index 55 is sampled.
  - Writing any value to 0x00 restores all registers to defaults.
  - Writes to 0x26 and 0x7C are ignored.
- Register read:
  - Condition: frame valid, slot1 valid, slot1[19] = 1.
  - Latches a pending response with the address and the register contents current at index 55 (after a same-frame write, if any).
  - The response goes out in the next frame: tag bits 14/13 = 1, slot1[18:12] = address, slot1[11:0] = 0, slot2[19:4] = data, slot2[3:0] = 0.
  - The pending response is cleared after it is sent once.
- DAC capture: when slot3 and slot4 are both valid, dac_left/dac_right update and dac_valid pulses in the cycle after index 95 is sampled.
- ADC loopback: samples captured in frame n are returned in slots 3/4 of frame n+1, with tag bits 12/11 = 1. With no capture in frame n, those tag bits and slots are 0.
- Output tag: bit15 = codec_ready; bit14/13 per read; bit12/11 per loopback; bits 10-0 = 0.
- Output timing:
  - The output frame is assembled when index 0 is sampled.
  - SDATA_IN is registered and carries output bit k during the cycle after input bit k is sampled (fixed 1-cycle lag).
  - SDATA_IN = 0 when no frame is open.
- codec_ready: asserted after READY_FRAMES completed frames (index 255 reached). Stays high until reset_n.
- Boundary conditions:
  - SYNC rising mid-frame: the partial frame is discarded (no write, no dac_valid, pending read kept) and index restarts at 0.
  - No SYNC at wrap: the counter keeps running free as the next frame.

Optional Feature:
- Macro AC97_SYNC_CHECK_EN.
- Defined:
  - sync_err sets when a SYNC rising edge occurs at an index other than 0 after wrap.
  - sync_err also sets when SYNC high-time is not exactly 16 cycles.
  - sync_err is cleared only by reset_n.
  - The frame is still resynchronised as described in Behaviour.
- Undefined: sync_err tied 0 and no check logic.

Decomposition:
- Package ac97_pkg:
  - slot start/end index constants and tag bit positions.
  - register indices 0x00/0x26/0x7C.
  - a slot-type typedef (20-bit).
- Sub-module ac97_regfile: 64x16 storage, default restore, write-protect list, combinational read port.

Test Plan:
- Reset, then send 6 valid empty frames -> codec_ready = 0 through frame 4; tag bit15 = 1 from the frame after the 4th completes.
- Write 0x02 = 0x8000 in frame n, read 0x02 in frame n+1 -> frame n+2 SDATA_IN tag = 0xE000 (bits 15/14/13), slot1 = 0x02000, slot2 = 0x80000.
- Read 0x7C -> slot2[19:4] = 0x4E53. Write 0x7C = 0x1234, then read -> still 0x4E53. Write 0x00, then read 0x02 -> 0x0000.
- Slots 3/4 = 0x7FFFF/0x80001 valid in frame n -> dac_valid pulse after index 95; frame n+1 slots 3/4 = same values, tag bits 12/11 = 1.
- SYNC re-asserted at index 40 in a frame carrying a write -> register unchanged, no dac_valid, new frame aligns at 0; with AC97_SYNC_CHECK_EN, sync_err = 1.
- reset_n low at index 70 of a read frame -> all outputs 0 immediately; no read response in later frames.
